// File: rtl/fpu_pkg.sv
// Shared FPU types and helpers: divider FSM states, exception flag indices,
// operand classification and the canonical quiet NaN.
package fpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NORM,
        ST_DIV,
        ST_ROUND,
        ST_DONE
    } fdiv_state_t;

    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } fp_class_t;

    // Caller reduces the fields so the function stays width-independent.
    function automatic fp_class_t fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic man_zero, input logic man_msb);
        fp_class_t c;
        if (exp_zero)      c = man_zero ? CLS_ZERO : CLS_SUB;
        else if (exp_ones) c = man_zero ? CLS_INF : (man_msb ? CLS_QNAN : CLS_SNAN);
        else               c = CLS_NORM;
        return c;
    endfunction

    // Sign 0, exponent all ones, mantissa MSB set; caller truncates to its width.
    function automatic logic [63:0] canon_nan(input int unsigned exp_w, input int unsigned man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Parametrised leading-zero counter; an all-zero input returns W.
module fpu_lzc
    import fpu_pkg::*;
#(
    parameter int unsigned W = 24,
    localparam int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  in_v,
    output logic [CW-1:0] cnt
);

    logic [W-1:0] v;

    // Shift until the MSB is set, counting the shifts.
    always_comb begin
        v   = in_v;
        cnt = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (!v[W-1]) begin
                v   = v << 1;
                cnt = cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/fdiv_iter.sv
// Iterative IEEE-754 divider: radix-2 restoring loop, RNE rounding, RISC-V flags.
// FDIV_SUBNORMAL_EN enables subnormal operands/results; otherwise they flush to zero.
module fdiv_iter
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 order,
    output logic                 accepted,
    output logic                 done,
    input  logic [EXP_W+MAN_W:0] rs1,
    input  logic [EXP_W+MAN_W:0] rs2,
    output logic [EXP_W+MAN_W:0] rd,
    output logic [4:0]           flags
);

    localparam int unsigned FW    = 1 + EXP_W + MAN_W;
    localparam int unsigned BIAS  = 2**(EXP_W-1) - 1;
    localparam int unsigned EMAX  = 2**EXP_W - 1;
    localparam int unsigned Q     = MAN_W + 3;
    localparam int unsigned EW    = EXP_W + 2;
    localparam int unsigned SW    = MAN_W + 1;
    localparam int unsigned RW    = MAN_W + 2;
    localparam int unsigned CNT_W = $clog2(Q);
    localparam logic [FW-1:0] QNAN_C = FW'(canon_nan(EXP_W, MAN_W));

    fdiv_state_t        state_q, state_d;
    logic               done_q, done_d;
    logic [FW-1:0]      rd_q, rd_d;
    logic [4:0]         flags_q, flags_d;
    logic               sign_q, sign_d;
    logic [EXP_W-1:0]   ea_q, ea_d, eb_q, eb_d;
    logic [SW-1:0]      ma_q, ma_d, mb_q, mb_d;
    logic [RW-1:0]      r_q, r_d;
    logic [Q-1:0]       q_q, q_d;
    logic [EW-1:0]      e_q, e_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Normalisation datapath (NORM state)
    logic [SW-1:0]      ma_n, mb_n;
    logic [EW-1:0]      ea_x, eb_x;

`ifdef FDIV_SUBNORMAL_EN
    localparam int unsigned LZW = $clog2(SW + 1);
    logic [LZW-1:0]     lz_a, lz_b;

    fpu_lzc #(.W(SW)) u_lzc_a (.in_v(ma_q), .cnt(lz_a));
    fpu_lzc #(.W(SW)) u_lzc_b (.in_v(mb_q), .cnt(lz_b));

    // A subnormal's exponent field 0 means 2^(1-BIAS), less the normalising shift.
    always_comb begin
        ma_n = ma_q << lz_a;
        mb_n = mb_q << lz_b;
        ea_x = EW'(ea_q) + EW'(ea_q == '0) - EW'(lz_a);
        eb_x = EW'(eb_q) + EW'(eb_q == '0) - EW'(lz_b);
    end
`else
    always_comb begin
        ma_n = ma_q;
        mb_n = mb_q;
        ea_x = EW'(ea_q);
        eb_x = EW'(eb_q);
    end
`endif

    // Rounding datapath (ROUND state)
    logic [Q-1:0]       qn, qs;
    logic [EW-1:0]      en, ef;
    logic               tiny, lost, grd, stk, inc, carry, nx;
    logic [SW-1:0]      mant;
    logic [RW-1:0]      mant_r;
    logic [MAN_W-1:0]   frac;
    logic [FW-1:0]      rnd_rd;
    logic [4:0]         rnd_flags;
`ifdef FDIV_SUBNORMAL_EN
    logic [EW-1:0]      sh;
`endif

    always_comb begin
        qn   = q_q[Q-1] ? q_q : (q_q << 1);
        en   = q_q[Q-1] ? e_q : (e_q - EW'(1));
        tiny = en[EW-1] | (en == '0);
`ifdef FDIV_SUBNORMAL_EN
        sh   = tiny ? (EW'(1) - en) : '0;
        qs   = qn >> sh;
        lost = |(qn & ~({Q{1'b1}} << sh));
`else
        qs   = qn;
        lost = 1'b0;
`endif
        mant   = qs[Q-1:2];
        grd    = qs[1];
        stk    = qs[0] | lost | (r_q != '0);
        inc    = grd & (stk | mant[0]);
        mant_r = {1'b0, mant} + RW'(inc);
        carry  = mant_r[RW-1];
        frac   = carry ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        ef     = en + EW'(carry);
        nx     = grd | stk;
        rnd_flags = '0;
        if (tiny) begin
`ifdef FDIV_SUBNORMAL_EN
            // Hidden bit reappearing after rounding encodes the minimum normal.
            rnd_rd = {sign_q, EXP_W'(mant_r[MAN_W]), mant_r[MAN_W-1:0]};
            rnd_flags[FLAG_UF] = nx;
            rnd_flags[FLAG_NX] = nx;
`else
            rnd_rd = {sign_q, {(FW-1){1'b0}}};
            rnd_flags[FLAG_UF] = 1'b1;
            rnd_flags[FLAG_NX] = 1'b1;
`endif
        end else if (ef >= EW'(EMAX)) begin
            rnd_rd = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_flags[FLAG_OF] = 1'b1;
            rnd_flags[FLAG_NX] = 1'b1;
        end else begin
            rnd_rd = {sign_q, ef[EXP_W-1:0], frac};
            rnd_flags[FLAG_NX] = nx;
        end
    end

    // Operand decode, special-case resolution and next-state logic
    logic [EXP_W-1:0]   ea_in, eb_in;
    fp_class_t          ca, cb;
    logic               a_nan, b_nan, za, zb, ia, ib, snan;
    logic               ge;
    logic [RW-1:0]      r_sub;

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        flags_d = flags_q;
        sign_d  = sign_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        r_d     = r_q;
        q_d     = q_q;
        e_d     = e_q;
        cnt_d   = cnt_q;

        accepted = order & ((state_q == ST_IDLE) | (state_q == ST_DONE));

        ea_in = rs1[FW-2:MAN_W];
        eb_in = rs2[FW-2:MAN_W];
        ca = fp_classify(ea_in == '0, &ea_in, rs1[MAN_W-1:0] == '0, rs1[MAN_W-1]);
        cb = fp_classify(eb_in == '0, &eb_in, rs2[MAN_W-1:0] == '0, rs2[MAN_W-1]);
`ifndef FDIV_SUBNORMAL_EN
        if (ca == CLS_SUB) ca = CLS_ZERO;
        if (cb == CLS_SUB) cb = CLS_ZERO;
`endif
        a_nan = (ca == CLS_QNAN) | (ca == CLS_SNAN);
        b_nan = (cb == CLS_QNAN) | (cb == CLS_SNAN);
        snan  = (ca == CLS_SNAN) | (cb == CLS_SNAN);
        za    = (ca == CLS_ZERO);
        zb    = (cb == CLS_ZERO);
        ia    = (ca == CLS_INF);
        ib    = (cb == CLS_INF);

        ge    = r_q >= RW'(mb_q);
        r_sub = ge ? (r_q - RW'(mb_q)) : r_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (order) begin
                    sign_d  = rs1[FW-1] ^ rs2[FW-1];
                    ea_d    = ea_in;
                    eb_d    = eb_in;
                    ma_d    = {ea_in != '0, rs1[MAN_W-1:0]};
                    mb_d    = {eb_in != '0, rs2[MAN_W-1:0]};
                    flags_d = '0;
                    state_d = ST_DONE;
                    if (a_nan | b_nan | (za & zb) | (ia & ib)) begin
                        rd_d = QNAN_C;
                        flags_d[FLAG_NV] = snan | (za & zb) | (ia & ib);
                    end else if (zb) begin
                        rd_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags_d[FLAG_DZ] = ~ia;
                    end else if (ia) begin
                        rd_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else if (ib | za) begin
                        rd_d = {sign_d, {(FW-1){1'b0}}};
                    end else begin
                        flags_d = flags_q;
                        state_d = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                r_d     = RW'(ma_n);
                mb_d    = mb_n;
                q_d     = '0;
                cnt_d   = '0;
                e_d     = ea_x - eb_x + EW'(BIAS);
                state_d = ST_DIV;
            end
            ST_DIV: begin
                r_d   = r_sub << 1;
                q_d   = {q_q[Q-2:0], ge};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(Q - 1)) state_d = ST_ROUND;
            end
            ST_ROUND: begin
                rd_d    = rnd_rd;
                flags_d = rnd_flags;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            rd_q    <= '0;
            flags_q <= '0;
            sign_q  <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            r_q     <= '0;
            q_q     <= '0;
            e_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            flags_q <= flags_d;
            sign_q  <= sign_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            r_q     <= r_d;
            q_q     <= q_d;
            e_q     <= e_d;
            cnt_q   <= cnt_d;
        end
    end

    assign done  = done_q;
    assign rd    = rd_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Self-checking bench for fdiv_iter (single precision) with a result scoreboard.
module tb_fdiv_iter;

    localparam logic [4:0] F_NV = 5'b10000;
    localparam logic [4:0] F_DZ = 5'b01000;
    localparam logic [4:0] F_OF = 5'b00100;
    localparam logic [4:0] F_UF = 5'b00010;
    localparam logic [4:0] F_NX = 5'b00001;

    logic        clk = 1'b0;
    logic        rst;
    logic        order;
    logic        accepted;
    logic        done;
    logic [31:0] rs1, rs2, rd;
    logic [4:0]  flags;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rd;
        logic [4:0]  fl;
        int          lat;
    } exp_t;

    exp_t sb[$];

    fdiv_iter #(.EXP_W(8), .MAN_W(23)) dut (
        .clk      (clk),
        .rst      (rst),
        .order    (order),
        .accepted (accepted),
        .done     (done),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .flags    (flags)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns 1 ns after the accept edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] erd,
                         input logic [4:0] efl, input int elat, output logic acc);
        exp_t e;
        e.rd  = erd;
        e.fl  = efl;
        e.lat = elat;
        sb.push_back(e);
        rs1   = a;
        rs2   = b;
        order = 1'b1;
        #1 acc = accepted;
        @(posedge clk);
        #1 order = 1'b0;
    endtask

    // n counts rising edges from the accept edge to the cycle where done is seen.
    task automatic wait_done(input int start, output int n, output logic to);
        n  = start;
        to = 1'b0;
        @(negedge clk);
        while (!done) begin
            if (n >= 64) begin
                to = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; order = 1'b0; rs1 = '0; rs2 = '0;
        #1;
        total++;
        if (done !== 1'b0 || rd !== 32'h0 || flags !== 5'h0 || accepted !== 1'b0) begin
            bad++;
            $display("FAIL reset done=%b rd=%h flags=%b acc=%b want 0/0/0/0", done, rd, flags, accepted);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_normal();
        logic [31:0] ta [5], tb2 [5], trd [5];
        logic [4:0]  tfl [5];
        logic acc, to;
        int n;
        exp_t e;
        ta  = '{32'h40C00000, 32'hC0C00000, 32'h41200000, 32'h40E00000, 32'h40000000};
        tb2 = '{32'h40000000, 32'h40000000, 32'h40800000, 32'hBF000000, 32'h40400000};
        trd = '{32'h40400000, 32'hC0400000, 32'h40200000, 32'hC1600000, 32'h3F2AAAAB};
        tfl = '{5'h0, 5'h0, 5'h0, 5'h0, F_NX};
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb2[i], trd[i], tfl[i], 29, acc);
            if (i == 0) begin
                // A request held high while busy must not be accepted.
                for (int k = 1; k <= 5; k++) begin
                    @(negedge clk);
                    order = 1'b1;
                    #1;
                    total++;
                    if (accepted !== 1'b0) begin
                        bad++;
                        $display("FAIL busy_accept cycle=%0d got=%b want=0", k, accepted);
                    end
                    if (k == 5) order = 1'b0;
                end
                wait_done(6, n, to);
            end else begin
                wait_done(1, n, to);
            end
            e = sb.pop_front();
            total++;
            if (acc !== 1'b1 || to || rd !== e.rd || flags !== e.fl || n != e.lat) begin
                bad++;
                $display("FAIL normal[%0d] rd got=%h want=%h flags got=%b want=%b lat got=%0d want=%0d acc=%b timeout=%b",
                         i, rd, e.rd, flags, e.fl, n, e.lat, acc, to);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic acc, to;
        int n;
        exp_t e;
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, F_NX, 29, acc);
        wait_done(1, n, to);
        e = sb.pop_front();
        total++;
        if (acc !== 1'b1 || to || rd !== e.rd || flags !== e.fl || n != e.lat) begin
            bad++;
            $display("FAIL b2b_first rd got=%h want=%h flags got=%b want=%b lat got=%0d want=%0d timeout=%b",
                     rd, e.rd, flags, e.fl, n, e.lat, to);
        end
        // Issue in the done cycle itself.
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'h0, 29, acc);
        total++;
        if (acc !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept_in_done got=%b want=1", acc);
        end
        wait_done(1, n, to);
        e = sb.pop_front();
        total++;
        if (to || rd !== e.rd || flags !== e.fl || n != e.lat) begin
            bad++;
            $display("FAIL b2b_second rd got=%h want=%h flags got=%b want=%b lat got=%0d want=%0d timeout=%b",
                     rd, e.rd, flags, e.fl, n, e.lat, to);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || rd !== 32'h40400000) begin
            bad++;
            $display("FAIL done_pulse done got=%b want=0 rd got=%h want=40400000", done, rd);
        end
    endtask

    task automatic test_special();
        logic [31:0] ta [9], tb2 [9], trd [9];
        logic [4:0]  tfl [9];
        logic acc, to;
        int n;
        exp_t e;
        ta  = '{32'h3F800000, 32'h00000000, 32'hFF800000, 32'h7F800000, 32'h7F800001,
                32'h7FC00001, 32'h40000000, 32'h80000000, 32'hC0000000};
        tb2 = '{32'h00000000, 32'h80000000, 32'h40000000, 32'hFF800000, 32'h3F800000,
                32'h00000000, 32'hFF800000, 32'h40400000, 32'h80000000};
        trd = '{32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h7FC00000,
                32'h7FC00000, 32'h80000000, 32'h80000000, 32'h7F800000};
        tfl = '{F_DZ, F_NV, 5'h0, F_NV, F_NV, 5'h0, 5'h0, 5'h0, F_DZ};
        for (int i = 0; i < 9; i++) begin
            issue(ta[i], tb2[i], trd[i], tfl[i], 1, acc);
            wait_done(1, n, to);
            e = sb.pop_front();
            total++;
            if (acc !== 1'b1 || to || rd !== e.rd || flags !== e.fl || n != e.lat) begin
                bad++;
                $display("FAIL special[%0d] rd got=%h want=%h flags got=%b want=%b lat got=%0d want=%0d acc=%b timeout=%b",
                         i, rd, e.rd, flags, e.fl, n, e.lat, acc, to);
            end
        end
    endtask

    task automatic test_range();
        logic [31:0] ta [5], tb2 [5], trd [5];
        logic [4:0]  tfl [5];
        int          tlat [5];
        logic acc, to;
        int n;
        exp_t e;
        ta  = '{32'h00800000, 32'h00400000, 32'h00800001, 32'h00FFFFFF, 32'h7F000000};
        tb2 = '{32'h40000000, 32'h3F000000, 32'h40000000, 32'h40000000, 32'h3E800000};
`ifdef FDIV_SUBNORMAL_EN
        trd  = '{32'h00400000, 32'h00800000, 32'h00400000, 32'h00800000, 32'h7F800000};
        tfl  = '{5'h0, 5'h0, F_UF | F_NX, F_UF | F_NX, F_OF | F_NX};
        tlat = '{29, 29, 29, 29, 29};
`else
        trd  = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h7F800000};
        tfl  = '{F_UF | F_NX, 5'h0, F_UF | F_NX, F_UF | F_NX, F_OF | F_NX};
        tlat = '{29, 1, 29, 29, 29};
`endif
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb2[i], trd[i], tfl[i], tlat[i], acc);
            wait_done(1, n, to);
            e = sb.pop_front();
            total++;
            if (acc !== 1'b1 || to || rd !== e.rd || flags !== e.fl || n != e.lat) begin
                bad++;
                $display("FAIL range[%0d] rd got=%h want=%h flags got=%b want=%b lat got=%0d want=%0d acc=%b timeout=%b",
                         i, rd, e.rd, flags, e.fl, n, e.lat, acc, to);
            end
        end
    endtask

    task automatic test_reset_mid_div();
        logic acc, to, seen;
        int n;
        exp_t e;
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'h0, 29, acc);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (done !== 1'b0 || rd !== 32'h0 || flags !== 5'h0) begin
            bad++;
            $display("FAIL async_reset done=%b rd=%h flags=%b want 0/0/0", done, rd, flags);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        seen = 1'b0;
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL aborted_op_done got=%b want=0", seen);
        end
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'h0, 29, acc);
        wait_done(1, n, to);
        e = sb.pop_front();
        total++;
        if (acc !== 1'b1 || to || rd !== e.rd || flags !== e.fl || n != e.lat) begin
            bad++;
            $display("FAIL after_reset rd got=%h want=%h flags got=%b want=%b lat got=%0d want=%0d acc=%b timeout=%b",
                     rd, e.rd, flags, e.fl, n, e.lat, acc, to);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_back_to_back();
        test_special();
        test_range();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fdiv_iter.md
# fdiv_iter

Parametrised iterative IEEE-754 floating-point divider for the FPU, the successor to the fixed single-precision divider. It supports any exponent/mantissa split and uses a radix-2 restoring quotient loop, one bit per cycle, instead of a wide combinational divide. It also adds round-to-nearest-even, full special-case handling and RISC-V-style exception flags. It sits beside the other FPU units and uses the core's order/accepted/done handshake.

## Interface
- EXP_W, 8, exponent width; BIAS = 2^(EXP_W-1)-1
- MAN_W, 23, stored mantissa width (hidden bit excluded); FW = 1+EXP_W+MAN_W
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- order  in  1  request; operands valid while high
- accepted  out  1  combinational: order & state in {IDLE, DONE}; operands captured this cycle
- done  out  1  one-cycle pulse, rd/flags valid
- rs1  in  FW  dividend
- rs2  in  FW  divisor
- rd  out  FW  quotient, registered, held until next done
- flags  out  5  {NV, DZ, OF, UF, NX}, registered alongside rd

## Operation
- States: IDLE, NORM, DIV, ROUND, DONE.
  - IDLE/DONE + accepted -> capture operands.
  - If the input is special -> DONE with rd/flags loaded; otherwise -> NORM.
  - DONE without accept -> IDLE.
- Special cases, in priority order:
  - Any NaN operand, 0/0 or inf/inf -> canonical qNaN: sign 0, exp all ones, mantissa MSB 1. NV is set only for sNaN, 0/0 and inf/inf.
  - finite/0 -> inf, DZ.
  - inf/x -> inf.
  - x/inf and 0/x -> zero.
  - Sign = s1^s2 except for NaN.
- NORM (1 cycle):
  - Exponent e = ea - eb + BIAS, signed, EXP_W+2 bits.
  - Subnormal handling depends on the macro (see Configuration).
- DIV runs Q = MAN_W+3 cycles, restoring:
  - if r >= mb: qbit = 1, r -= mb; then r <<= 1.
  - Initial r = ma. Both significands are MAN_W+1 bits with hidden bit; r is MAN_W+2 bits.
- ROUND (1 cycle):
  - If q MSB = 0: shift q left 1 and decrement e.
  - Take MAN_W+1 significant bits, guard = next bit, sticky = remaining bit | (r != 0).
  - RNE: increment if guard & (sticky | lsb). A mantissa carry increments e.
  - NX = guard | sticky.
  - e >= 2^EXP_W-1 -> inf, OF|NX.
  - e <= 0 -> underflow path.
- order deasserted mid-operation: ignored; the operation completes.

## Timing
- Accept edge = cycle 0.
- Normal path: NORM cycle 1, DIV cycles 2..Q+1, ROUND cycle Q+2. done = 1 in cycle Q+3, i.e. 29 cycles for EXP_W=8/MAN_W=23.
- Special path: done in cycle 1.
- Accept is allowed in the DONE cycle, so back-to-back issue interval is Q+3.
- Reset is asynchronous: state IDLE, done 0, rd 0, flags 0, quotient/remainder registers 0, effective immediately, including mid-DIV.

## Configuration
- FDIV_SUBNORMAL_EN defined:
  - NORM left-normalises subnormal operands via leading-zero count and adjusts e.
  - Results with e <= 0 are right-shifted by 1-e, with shifted-out bits ORed into sticky, before RNE.
  - UF is set when the result is tiny and inexact.
  - A rounding carry into the normal range yields the minimum normal.
- Undefined:
  - Subnormal inputs are treated as signed zero.
  - e <= 0 gives signed zero with UF|NX.

## Structure
- Shared package fpu_pkg:
  - state enum fdiv_state_t;
  - flag bit indices FLAG_NV..FLAG_NX;
  - operand class enum (zero, subnormal, normal, inf, qnan, snan) and its classify function;
  - canonical-NaN constant function of EXP_W/MAN_W.
- One sub-module: fpu_lzc (parametrised leading-zero counter), instantiated only under FDIV_SUBNORMAL_EN.

## Test plan
- 0x40C00000 / 0x40000000 -> rd 0x40400000, flags 0, done exactly 29 cycles after accepted.
- 0x3F800000 / 0x40400000 -> rd 0x3EAAAAAB, flags NX; back-to-back second order accepted in the done cycle.
- 0x3F800000 / 0x00000000 -> rd 0x7F800000, DZ, done at cycle 1. 0x00000000 / 0x80000000 -> rd 0x7FC00000, NV.
- 0x7F000000 / 0x3E800000 -> rd 0x7F800000, OF|NX. 0xFF800000 / 0x40000000 -> rd 0xFF800000, flags 0.
- 0x00800000 / 0x40000000:
  - with FDIV_SUBNORMAL_EN -> rd 0x00400000, flags 0;
  - without -> rd 0x00000000, UF|NX.
- rst pulsed at cycle 10 of DIV -> done, rd, flags 0 asynchronously. Then 0x40C00000 / 0x40000000 after release -> 0x40400000.
